rd1_ddr_addr_gen: RTL and testbench

//  Read-channel-1 DDR burst address generator; sits directly upstream of the rd1 DDR address prefetch FIFO.
//  - On a frame request, walks a rectangular frame (LINES x BURSTS per line, with LINE_STRIDE between lines).
//  - Pushes one packed burst descriptor per FIFO write, using the FIFO wr_en/wr_vld handshake.

---
 rtl/rd1_ddr_addr_gen.sv | 141 ++++++++++++++
 tb/tb_rd1_ddr_addr_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd1_ddr_addr_gen.sv
// Read-channel-1 DDR burst address generator.
// Walks a LINES x BURSTS frame and pushes {eol, eof, addr} descriptors into the prefetch FIFO.
module rd1_ddr_addr_gen #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_BYTES = 256,
  parameter int CNT_WIDTH   = 12,
  parameter int DATA_WIDTH  = ADDR_WIDTH + 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  frame_start,
  input  logic                  frame_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_line_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  input  logic [CNT_WIDTH-1:0]  cfg_bursts,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  wr_vld,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  start_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] line_start_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  lines_q;
  logic [CNT_WIDTH-1:0]  bursts_q;
  logic [CNT_WIDTH-1:0]  burst_cnt_q;
  logic [CNT_WIDTH-1:0]  line_cnt_q;
  logic                  eol_q;
  logic                  eof_q;
  logic                  wr_en_q;
  logic                  overrun_q;

  logic                  xfer;
  logic                  last_b;
  logic                  last_l;
  logic [CNT_WIDTH-1:0]  nxt_burst;
  logic [CNT_WIDTH-1:0]  nxt_line;
  logic [ADDR_WIDTH-1:0] nxt_line_start;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_eol;
  logic                  nxt_eof;

  // Counters track the descriptor currently on wr_data; flags are
  // computed for the next one so they register alongside its address.
  always_comb begin
    xfer           = wr_en_q & wr_vld;
    last_b         = (burst_cnt_q == bursts_q - CNT_ONE);
    last_l         = (line_cnt_q == lines_q - CNT_ONE);
    nxt_burst      = last_b ? '0 : burst_cnt_q + CNT_ONE;
    nxt_line       = last_b ? line_cnt_q + CNT_ONE : line_cnt_q;
    nxt_line_start = last_b ? line_start_q + stride_q : line_start_q;
    nxt_addr       = last_b ? nxt_line_start : addr_q + BURST_INC;
    nxt_eol        = (nxt_burst == bursts_q - CNT_ONE);
    nxt_eof        = nxt_eol && (nxt_line == lines_q - CNT_ONE);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      line_start_q <= '0;
      stride_q     <= '0;
      lines_q      <= '0;
      bursts_q     <= '0;
      burst_cnt_q  <= '0;
      line_cnt_q   <= '0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= frame_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            stride_q     <= cfg_line_stride;
            lines_q      <= cfg_lines;
            bursts_q     <= cfg_bursts;
            addr_q       <= cfg_base_addr;
            line_start_q <= cfg_base_addr;
            burst_cnt_q  <= '0;
            line_cnt_q   <= '0;
            eol_q        <= (cfg_bursts == CNT_ONE);
            eof_q        <= (cfg_bursts == CNT_ONE) &&
                            (cfg_lines == CNT_ONE);
            if (cfg_lines == '0 || cfg_bursts == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_ISSUE;
              wr_en_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (frame_abort) begin
            state   <= S_IDLE;
            wr_en_q <= 1'b0;
          end else if (xfer) begin
            if (last_b && last_l) begin
              state   <= S_DONE;
              wr_en_q <= 1'b0;
            end else begin
              addr_q       <= nxt_addr;
              line_start_q <= nxt_line_start;
              burst_cnt_q  <= nxt_burst;
              line_cnt_q   <= nxt_line;
              eol_q        <= nxt_eol;
              eof_q        <= nxt_eof;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_data       = {eol_q, eof_q, addr_q};
  assign wr_en         = wr_en_q;
  assign busy          = (state != S_IDLE);
  assign frame_done    = (state == S_DONE);
  assign start_overrun = overrun_q;

endmodule

// File: tb/tb_rd1_ddr_addr_gen.sv
// Directed self-checking bench for rd1_ddr_addr_gen.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_rd1_ddr_addr_gen;

  localparam int AW = 28;
  localparam int CW = 12;
  localparam int DW = AW + 2;

  logic          wr_clk;
  logic          wr_rst;
  logic          frame_start;
  logic          frame_abort;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_line_stride;
  logic [CW-1:0] cfg_lines;
  logic [CW-1:0] cfg_bursts;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_vld;
  logic          busy;
  logic          frame_done;
  logic          start_overrun;

  int n_run;
  int n_fail;
  int xfer_cnt;

  rd1_ddr_addr_gen #(
    .ADDR_WIDTH (AW),
    .BURST_BYTES(256),
    .CNT_WIDTH  (CW),
    .DATA_WIDTH (DW)
  ) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .frame_start    (frame_start),
    .frame_abort    (frame_abort),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_line_stride(cfg_line_stride),
    .cfg_lines      (cfg_lines),
    .cfg_bursts     (cfg_bursts),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_vld         (wr_vld),
    .busy           (busy),
    .frame_done     (frame_done),
    .start_overrun  (start_overrun)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk)
    if (!wr_rst && wr_en && wr_vld) xfer_cnt++;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] base,
                             input logic [AW-1:0] stride,
                             input logic [CW-1:0] lines,
                             input logic [CW-1:0] bursts);
    cfg_base_addr   = base;
    cfg_line_stride = stride;
    cfg_lines       = lines;
    cfg_bursts      = bursts;
    frame_start     = 1'b1;
    tick();
    frame_start     = 1'b0;
    cfg_base_addr   = '1;
    cfg_line_stride = '1;
    cfg_lines       = '1;
    cfg_bursts      = '1;
  endtask

  task automatic test_reset();
    wr_rst = 1'b1;
    tick();
    tick();
    n_run++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en);
    end
    n_run++;
    if (wr_data !== '0) begin
      n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_data);
    end
    n_run++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || start_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got busy=%b done=%b ovr=%b want 000",
               busy, frame_done, start_overrun);
    end
    wr_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [AW-1:0] ea [6];
    logic          el [6];
    int            x0;
    ea = '{28'h100, 28'h200, 28'h300, 28'h1100, 28'h1200, 28'h1300};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    x0 = xfer_cnt;
    start_frame(28'h100, 28'h1000, 12'd2, 12'd3);
    n_run++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL t1_busy got %b want 1", busy);
    end
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (wr_en !== 1'b1 || wr_data !== {el[i], (i == 5), ea[i]}) begin
        n_fail++;
        $display("FAIL t1_desc%0d got en=%b data=%h want en=1 data=%h",
                 i, wr_en, wr_data, {el[i], (i == 5), ea[i]});
      end
      tick();
    end
    n_run++;
    if (wr_en !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_done got en=%b done=%b busy=%b want 0 1 1",
               wr_en, frame_done, busy);
    end
    tick();
    n_run++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_idle got done=%b busy=%b want 0 0", frame_done, busy);
    end
    n_run++;
    if (xfer_cnt - x0 !== 6) begin
      n_fail++; $display("FAIL t1_count got %0d want 6", xfer_cnt - x0);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] ea [6];
    int            x0;
    ea = '{28'h100, 28'h200, 28'h300, 28'h1100, 28'h1200, 28'h1300};
    x0 = xfer_cnt;
    start_frame(28'h100, 28'h1000, 12'd2, 12'd3);
    tick();
    wr_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (wr_en !== 1'b1 || wr_data !== {2'b00, 28'h200}) begin
        n_fail++;
        $display("FAIL t2_hold%0d got en=%b data=%h want en=1 data=%h",
                 k, wr_en, wr_data, {2'b00, 28'h200});
      end
      tick();
    end
    wr_vld = 1'b1;
    for (int i = 1; i < 6; i++) begin
      n_run++;
      if (wr_en !== 1'b1 || wr_data[AW-1:0] !== ea[i]) begin
        n_fail++;
        $display("FAIL t2_desc%0d got en=%b addr=%h want en=1 addr=%h",
                 i, wr_en, wr_data[AW-1:0], ea[i]);
      end
      tick();
    end
    n_run++;
    if (frame_done !== 1'b1 || xfer_cnt - x0 !== 6) begin
      n_fail++;
      $display("FAIL t2_done got done=%b xfers=%0d want 1 6",
               frame_done, xfer_cnt - x0);
    end
    tick();
  endtask

  task automatic test_empty_frame(input logic [CW-1:0] lines,
                                  input logic [CW-1:0] bursts);
    int x0;
    x0 = xfer_cnt;
    start_frame(28'h700, 28'h1000, lines, bursts);
    n_run++;
    if (wr_en !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_done l=%0d b=%0d got en=%b done=%b busy=%b want 0 1 1",
               lines, bursts, wr_en, frame_done, busy);
    end
    tick();
    n_run++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || xfer_cnt !== x0) begin
      n_fail++;
      $display("FAIL t3_idle got done=%b busy=%b xfers=%0d want 0 0 0",
               frame_done, busy, xfer_cnt - x0);
    end
  endtask

  task automatic test_wrap();
    start_frame(28'hFFFFF00, 28'h0, 12'd1, 12'd2);
    n_run++;
    if (wr_en !== 1'b1 || wr_data !== {2'b00, 28'hFFFFF00}) begin
      n_fail++;
      $display("FAIL t4_first got %h want %h", wr_data, {2'b00, 28'hFFFFF00});
    end
    tick();
    n_run++;
    if (wr_en !== 1'b1 || wr_data !== {2'b11, 28'h0000000}) begin
      n_fail++;
      $display("FAIL t4_wrap got %h want %h", wr_data, {2'b11, 28'h0000000});
    end
    tick();
    n_run++;
    if (frame_done !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_done got done=%b en=%b want 1 0", frame_done, wr_en);
    end
    tick();
  endtask

  task automatic test_overrun();
    start_frame(28'h4000, 28'h0, 12'd1, 12'd4);
    tick();
    cfg_base_addr = 28'h9000;
    cfg_lines     = 12'd3;
    cfg_bursts    = 12'd3;
    frame_start   = 1'b1;
    tick();
    frame_start   = 1'b0;
    n_run++;
    if (start_overrun !== 1'b1 || wr_data !== {2'b00, 28'h4200}) begin
      n_fail++;
      $display("FAIL t5_ovr got ovr=%b data=%h want 1 %h",
               start_overrun, wr_data, {2'b00, 28'h4200});
    end
    tick();
    n_run++;
    if (start_overrun !== 1'b0 || wr_data !== {2'b11, 28'h4300}) begin
      n_fail++;
      $display("FAIL t5_last got ovr=%b data=%h want 0 %h",
               start_overrun, wr_data, {2'b11, 28'h4300});
    end
    tick();
    n_run++;
    if (frame_done !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_done got done=%b en=%b want 1 0", frame_done, wr_en);
    end
    tick();
  endtask

  task automatic test_abort();
    int x0;
    x0 = xfer_cnt;
    start_frame(28'h100, 28'h1000, 12'd2, 12'd3);
    tick();
    tick();
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    n_run++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_abort got en=%b busy=%b done=%b want 0 0 0",
               wr_en, busy, frame_done);
    end
    n_run++;
    if (xfer_cnt - x0 !== 3) begin
      n_fail++; $display("FAIL t6_count got %0d want 3", xfer_cnt - x0);
    end
    tick();
    n_run++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL t6_nodone got %b want 0", frame_done);
    end
    start_frame(28'h5000, 28'h0, 12'd1, 12'd1);
    n_run++;
    if (wr_en !== 1'b1 || wr_data !== {2'b11, 28'h5000}) begin
      n_fail++;
      $display("FAIL t6_restart got en=%b data=%h want 1 %h",
               wr_en, wr_data, {2'b11, 28'h5000});
    end
    tick();
    n_run++;
    if (frame_done !== 1'b1) begin
      n_fail++; $display("FAIL t6_redone got %b want 1", frame_done);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    start_frame(28'h100, 28'h1000, 12'd2, 12'd3);
    tick();
    #2;
    wr_rst = 1'b1;
    #1;
    n_run++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL t7_rst got en=%b busy=%b data=%h want 0 0 0",
               wr_en, busy, wr_data);
    end
    tick();
    wr_rst = 1'b0;
    tick();
    n_run++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t7_after got en=%b busy=%b want 0 0", wr_en, busy);
    end
  endtask

  initial begin
    n_run           = 0;
    n_fail          = 0;
    xfer_cnt        = 0;
    wr_rst          = 1'b1;
    frame_start     = 1'b0;
    frame_abort     = 1'b0;
    wr_vld          = 1'b1;
    cfg_base_addr   = '0;
    cfg_line_stride = '0;
    cfg_lines       = '0;
    cfg_bursts      = '0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_empty_frame(12'd0, 12'd3);
    test_empty_frame(12'd2, 12'd0);
    test_wrap();
    test_overrun();
    test_abort();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
